// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, unsigned or two's-complement.
// Optional multiply-accumulate (result = a*b + c) enabled by defining SEQ_MULT_ACC_EN.
module seq_mult_unit #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
`ifdef SEQ_MULT_ACC_EN
    input  logic [WIDTH-1:0]     c_in,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   p_q;
    logic [CNT_W-1:0]   cnt;
    logic               mode;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;

    // Widen by one bit: sign bit replicated only in two's-complement mode.
    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v, input logic m);
        return {m & v[WIDTH-1], v};
    endfunction

    // The multiplier's MSB carries weight -2^(WIDTH-1) when signed, so the last step subtracts.
    always_comb begin
        addend = a_q[0] ? b_q : '0;
        if (mode && (cnt == LAST_STEP))
            sum = ext(p_q, mode) - ext(addend, mode);
        else
            sum = ext(p_q, mode) + ext(addend, mode);
    end

    assign result = {p_q, a_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    p_q <= sum[WIDTH:1];
                    a_q <= {sum[0], a_q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, giving back-to-back operation.
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_q   <= a_in;
                        b_q   <= b_in;
                        mode  <= sgn;
                        cnt   <= '0;
`ifdef SEQ_MULT_ACC_EN
                        p_q   <= c_in;
`else
                        p_q   <= '0;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboard bench for seq_mult_unit (WIDTH=24): directed operands with hand-computed products.
module tb_seq_mult_unit;

    localparam int W = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sgn = 1'b0;
    logic [W-1:0]      a_in = '0;
    logic [W-1:0]      b_in = '0;
`ifdef SEQ_MULT_ACC_EN
    logic [W-1:0]      c_in = '0;
`endif
    logic              busy;
    logic              done;
    logic [2*W-1:0]    result;

    int total = 0;
    int bad = 0;
    int overlap = 0;
    logic [2*W-1:0] exp_q[$];

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sgn    (sgn),
        .a_in   (a_in),
        .b_in   (b_in),
`ifdef SEQ_MULT_ACC_EN
        .c_in   (c_in),
`endif
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done && busy) overlap++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(result), 64'hDEAD);
                end else begin
                    chk("result", 64'(result), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] c, input logic [2*W-1:0] expv,
                         input int glitch);
        int cyc;
        int nb;
        cyc = 0;
        nb = 0;
        start = 1'b1;
        a_in = a;
        b_in = b;
        sgn = s;
`ifdef SEQ_MULT_ACC_EN
        c_in = c;
`else
        if (c != '0) $display("note: addend ignored without accumulate build");
`endif
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in = 24'h5A5A5A;
        b_in = 24'hA5A5A5;
        sgn = ~s;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (busy) nb++;
            if (glitch != 0 && cyc == glitch) begin
                start = 1'b1;
                a_in = 24'h000009;
                b_in = 24'h000009;
            end else begin
                start = 1'b0;
            end
        end
        chk({name, "_latency"}, 64'(cyc), 64'd25);
        chk({name, "_busy_cycles"}, 64'(nb), 64'd24);
        @(negedge clk);
        chk({name, "_hold"}, 64'(result), 64'(expv));
        chk({name, "_done_low"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cyc;
        int nd;
        int dcyc[3];
        int errs;

        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("u_max", 24'hFFFFFF, 24'hFFFFFF, 1'b0, '0, 48'hFFFFFE000001, 0);
        do_op("s_m1m1", 24'hFFFFFF, 24'hFFFFFF, 1'b1, '0, 48'h000000000001, 0);
        do_op("s_minmin", 24'h800000, 24'h800000, 1'b1, '0, 48'h400000000000, 0);
        do_op("s_3m5", 24'h000003, 24'hFFFFFB, 1'b1, '0, 48'hFFFFFFFFFFF1, 0);
        do_op("u_glitch", 24'h000123, 24'h000456, 1'b0, '0, 48'h00000004EDC2, 10);

        // Start held high: three back-to-back operations.
        start = 1'b1;
        a_in = 24'd5;
        b_in = 24'd7;
        sgn = 1'b0;
        repeat (3) exp_q.push_back(48'd35);
        @(posedge clk);
        cyc = 0;
        nd = 0;
        errs = 0;
        while (cyc < 200 && nd < 3) begin
            @(negedge clk);
            cyc++;
            if (busy == done) errs++;
            if (done) begin
                dcyc[nd] = cyc;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("held_done_count", 64'(nd), 64'd3);
        chk("held_first_done", 64'(dcyc[0]), 64'd25);
        chk("held_period1", 64'(dcyc[1] - dcyc[0]), 64'd25);
        chk("held_period2", 64'(dcyc[2] - dcyc[1]), 64'd25);
        chk("held_busy_vs_done", 64'(errs), 64'd0);
        @(negedge clk);
        chk("held_idle_busy", 64'(busy), 64'd0);

        // Reset mid-operation: outputs clear at once and no done follows.
        start = 1'b1;
        a_in = 24'h000111;
        b_in = 24'h000222;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        do_op("after_abort", 24'd2, 24'd3, 1'b0, '0, 48'd6, 0);

`ifdef SEQ_MULT_ACC_EN
        do_op("acc_u", 24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'hFFFFFF, 48'hFFFFFF000000, 0);
        do_op("acc_s", 24'd2, 24'd3, 1'b1, 24'hFFFFFF, 48'h000000000005, 0);
`endif

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_busy_overlap", 64'(overlap), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
